// File: rtl/hazard_bypass_unit_pkg.sv
// Shared types for the hazard/bypass unit: select codes,
// FSM states and the in-flight destination tracker slot.
package hazard_bypass_unit_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 4;

    localparam logic [REG_W-1:0] NOREG = 4'hF;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b11;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dst;
        logic             is_load;
    } slot_t;

    localparam slot_t IDLE_SLOT = '{
        valid:   1'b0,
        dst:     NOREG,
        is_load: 1'b0
    };

    // NOREG is never a real producer, so it can never match a reader.
    function automatic logic slot_hit(
        input slot_t            s,
        input logic [REG_W-1:0] src,
        input logic             en
    );
        return en && s.valid && (s.dst != NOREG) && (s.dst == src);
    endfunction

endpackage

// File: rtl/hazard_bypass_unit_bypass_mux.sv
// Per-operand producer match and 4:1 operand select,
// youngest in-flight producer first.
module bypass_mux
    import hazard_bypass_unit_pkg::*;
(
    input  logic [REG_W-1:0]  src,
    input  logic              use_src,
    input  slot_t             ex_slot,
    input  slot_t             mem_slot,
    input  slot_t             wb_slot,
    input  logic [DATA_W-1:0] rf_data,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [DATA_W-1:0] wb_result,
    output logic [1:0]        sel,
    output logic [DATA_W-1:0] op,
    output logic              ex_hit
);

    logic mem_hit;
    logic wb_hit;

    assign ex_hit  = slot_hit(ex_slot, src, use_src);
    assign mem_hit = slot_hit(mem_slot, src, use_src);
    assign wb_hit  = slot_hit(wb_slot, src, use_src);

    // A load in EX has no data yet; fall through and let the stall cover it.
    always_comb begin
        sel = SEL_RF;
        if (ex_hit && !ex_slot.is_load) begin
            sel = SEL_EX;
        end else if (mem_hit) begin
            sel = SEL_MEM;
        end else if (wb_hit) begin
            sel = SEL_WB;
        end
    end

    always_comb begin
        op = rf_data;
        unique case (sel)
            SEL_RF:  op = rf_data;
            SEL_EX:  op = ex_result;
            SEL_MEM: op = mem_result;
            SEL_WB:  op = wb_result;
        endcase
    end

endmodule

// File: rtl/hazard_bypass_unit.sv
// Tracks EX/MEM/WB destinations, drives operand bypass and
// the stall/bubble/freeze controls for the front pipeline.
module hazard_bypass_unit
    import hazard_bypass_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_W-1:0]  id_src_a,
    input  logic [REG_W-1:0]  id_src_b,
    input  logic              id_use_a,
    input  logic              id_use_b,
    input  logic [REG_W-1:0]  id_dst,
    input  logic              id_is_load,
    input  logic              flush,
    input  logic              mem_busy,
    input  logic [DATA_W-1:0] rf_a,
    input  logic [DATA_W-1:0] rf_b,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [DATA_W-1:0] wb_result,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [1:0]        sel_a,
    output logic [1:0]        sel_b,
    output logic              stall,
    output logic              bubble,
    output logic              freeze
);

    slot_t  ex_q;
    slot_t  mem_q;
    slot_t  wb_q;
    slot_t  ex_d;
    state_e state_q;
    state_e state_d;

    logic ex_hit_a;
    logic ex_hit_b;
    logic load_use;
    logic advance;
    logic kill;

    bypass_mux u_mux_a (
        .src        (id_src_a),
        .use_src    (id_use_a),
        .ex_slot    (ex_q),
        .mem_slot   (mem_q),
        .wb_slot    (wb_q),
        .rf_data    (rf_a),
        .ex_result  (ex_result),
        .mem_result (mem_result),
        .wb_result  (wb_result),
        .sel        (sel_a),
        .op         (op_a),
        .ex_hit     (ex_hit_a)
    );

    bypass_mux u_mux_b (
        .src        (id_src_b),
        .use_src    (id_use_b),
        .ex_slot    (ex_q),
        .mem_slot   (mem_q),
        .wb_slot    (wb_q),
        .rf_data    (rf_b),
        .ex_result  (ex_result),
        .mem_result (mem_result),
        .wb_result  (wb_result),
        .sel        (sel_b),
        .op         (op_b),
        .ex_hit     (ex_hit_b)
    );

    assign load_use = ex_q.is_load && (ex_hit_a || ex_hit_b);

    // Event priority: mem_busy, then flush, then load-use.
    always_comb begin
        stall   = 1'b0;
        bubble  = 1'b0;
        freeze  = 1'b0;
        advance = 1'b0;
        kill    = 1'b0;
        state_d = state_q;
        if (rst) begin
            unique case (state_q)
                RUN:  state_d = mem_busy ? WAIT : RUN;
                WAIT: state_d = mem_busy ? WAIT : RUN;
            endcase
            if (mem_busy) begin
                freeze = 1'b1;
                stall  = 1'b1;
            end else if (flush) begin
                bubble  = 1'b1;
                advance = 1'b1;
                kill    = 1'b1;
            end else if (load_use) begin
                stall   = 1'b1;
                bubble  = 1'b1;
                advance = 1'b1;
                kill    = 1'b1;
            end else begin
                advance = 1'b1;
            end
        end
    end

    always_comb begin
        ex_d = IDLE_SLOT;
        if (!kill) begin
            ex_d = '{valid: 1'b1, dst: id_dst, is_load: id_is_load};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q    <= IDLE_SLOT;
            mem_q   <= IDLE_SLOT;
            wb_q    <= IDLE_SLOT;
            state_q <= RUN;
        end else begin
            state_q <= state_d;
            if (advance) begin
                ex_q  <= ex_d;
                mem_q <= ex_q;
                wb_q  <= mem_q;
            end
        end
    end

endmodule

// File: tb/tb_hazard_bypass_unit.sv
// Scenario bench for hazard_bypass_unit: per-cycle stimulus
// tables, expected outputs queued and checked each cycle.
module tb_hazard_bypass_unit;
    import hazard_bypass_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  id_src_a = '0;
    logic [3:0]  id_src_b = '0;
    logic        id_use_a = 1'b0;
    logic        id_use_b = 1'b0;
    logic [3:0]  id_dst = 4'hF;
    logic        id_is_load = 1'b0;
    logic        flush = 1'b0;
    logic        mem_busy = 1'b0;
    logic [15:0] rf_a = 16'hA0A0;
    logic [15:0] rf_b = 16'hB0B0;
    logic [15:0] ex_result = 16'h1234;
    logic [15:0] mem_result = 16'hBEEF;
    logic [15:0] wb_result = 16'hC0DE;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [1:0]  sel_a;
    logic [1:0]  sel_b;
    logic        stall;
    logic        bubble;
    logic        freeze;

    always #5 clk = ~clk;

    hazard_bypass_unit dut (
        .clk        (clk),
        .rst        (rst),
        .id_src_a   (id_src_a),
        .id_src_b   (id_src_b),
        .id_use_a   (id_use_a),
        .id_use_b   (id_use_b),
        .id_dst     (id_dst),
        .id_is_load (id_is_load),
        .flush      (flush),
        .mem_busy   (mem_busy),
        .rf_a       (rf_a),
        .rf_b       (rf_b),
        .ex_result  (ex_result),
        .mem_result (mem_result),
        .wb_result  (wb_result),
        .op_a       (op_a),
        .op_b       (op_b),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .stall      (stall),
        .bubble     (bubble),
        .freeze     (freeze)
    );

    // {sel_a, sel_b, op_a, op_b, stall, bubble, freeze}
    logic [38:0] obs;
    assign obs = {sel_a, sel_b, op_a, op_b, stall, bubble, freeze};

    typedef struct packed {
        logic       rs;
        logic [3:0] sa;
        logic       ua;
        logic [3:0] sb;
        logic       ub;
        logic [3:0] dst;
        logic       ld;
        logic       fl;
        logic       bz;
        logic [1:0] xa;
        logic [1:0] xb;
        logic       xs;
        logic       xbu;
        logic       xf;
    } step_t;

    typedef struct {
        string       tag;
        logic [38:0] v;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic step_t st(
        input logic rs, input logic [3:0] sa, input logic ua,
        input logic [3:0] sb, input logic ub, input logic [3:0] dst,
        input logic ld, input logic fl, input logic bz,
        input logic [1:0] xa, input logic [1:0] xb,
        input logic xs, input logic xbu, input logic xf
    );
        step_t s;
        s = '{rs, sa, ua, sb, ub, dst, ld, fl, bz, xa, xb, xs, xbu, xf};
        return s;
    endfunction

    function automatic logic [15:0] pick(
        input logic [1:0] s, input logic [15:0] rf
    );
        case (s)
            2'b00:   return rf;
            2'b01:   return ex_result;
            2'b10:   return mem_result;
            default: return wb_result;
        endcase
    endfunction

    function automatic logic [38:0] exp_of(input step_t s);
        return {s.xa, s.xb, pick(s.xa, rf_a), pick(s.xb, rf_b),
                s.xs, s.xbu, s.xf};
    endfunction

    task automatic apply(input step_t s);
        rst        = s.rs;
        id_src_a   = s.sa;
        id_use_a   = s.ua;
        id_src_b   = s.sb;
        id_use_b   = s.ub;
        id_dst     = s.dst;
        id_is_load = s.ld;
        flush      = s.fl;
        mem_busy   = s.bz;
        rf_a       = 16'($urandom);
        rf_b       = 16'($urandom);
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b0;
        flush = 1'b0;
        mem_busy = 1'b0;
        id_use_a = 1'b0;
        id_use_b = 1'b0;
        id_dst = 4'hF;
        id_is_load = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset;
        step_t s[$];
        exp_t  e;
        for (int i = 0; i < 3; i++) begin
            s.push_back(st(0, 4'($urandom), 1'($urandom), 4'($urandom),
                           1'($urandom), 4'($urandom), 1'($urandom),
                           1'($urandom), 1, 0, 0, 0, 0, 0));
        end
        s.push_back(st(1, 1, 1, 2, 1, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(st(1, 3, 1, 4, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (s[i]) begin
            @(negedge clk);
            apply(s[i]);
            e.tag = $sformatf("reset[%0d]", i);
            e.v = exp_of(s[i]);
            sbq.push_back(e);
            #1;
            e = sbq.pop_front();
            n_cmp++;
            if (obs !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic test_ex_bypass;
        step_t s[$];
        exp_t  e;
        do_reset();
        s.push_back(st(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(st(1, 1, 1, 0, 0, 5, 0, 0, 0, 1, 0, 0, 0, 0));
        s.push_back(st(1, 1, 1, 5, 1, 4'hF, 0, 0, 0, 2, 1, 0, 0, 0));
        s.push_back(st(1, 1, 1, 5, 1, 4'hF, 0, 0, 0, 3, 2, 0, 0, 0));
        s.push_back(st(1, 1, 1, 5, 1, 4'hF, 0, 0, 0, 0, 3, 0, 0, 0));
        foreach (s[i]) begin
            @(negedge clk);
            apply(s[i]);
            e.tag = $sformatf("ex_bypass[%0d]", i);
            e.v = exp_of(s[i]);
            sbq.push_back(e);
            #1;
            e = sbq.pop_front();
            n_cmp++;
            if (obs !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic test_load_use;
        step_t s[$];
        exp_t  e;
        do_reset();
        s.push_back(st(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(st(1, 0, 0, 2, 1, 6, 0, 0, 0, 0, 0, 1, 1, 0));
        s.push_back(st(1, 0, 0, 2, 1, 6, 0, 0, 0, 0, 2, 0, 0, 0));
        s.push_back(st(1, 6, 1, 2, 1, 4'hF, 0, 0, 0, 1, 3, 0, 0, 0));
        foreach (s[i]) begin
            @(negedge clk);
            apply(s[i]);
            e.tag = $sformatf("load_use[%0d]", i);
            e.v = exp_of(s[i]);
            sbq.push_back(e);
            #1;
            e = sbq.pop_front();
            n_cmp++;
            if (obs !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic test_priority;
        step_t s[$];
        exp_t  e;
        do_reset();
        s.push_back(st(1, 3, 0, 7, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(st(1, 3, 0, 7, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(st(1, 3, 0, 7, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(st(1, 3, 1, 7, 1, 4'hF, 0, 0, 1, 1, 2, 1, 0, 1));
        s.push_back(st(1, 3, 0, 7, 1, 4'hF, 0, 0, 0, 0, 2, 0, 0, 0));
        s.push_back(st(1, 4'hF, 1, 7, 1, 4'hF, 0, 0, 0, 0, 3, 0, 0, 0));
        foreach (s[i]) begin
            @(negedge clk);
            apply(s[i]);
            e.tag = $sformatf("priority[%0d]", i);
            e.v = exp_of(s[i]);
            sbq.push_back(e);
            #1;
            e = sbq.pop_front();
            n_cmp++;
            if (obs !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic test_mem_wait;
        step_t s[$];
        exp_t  e;
        do_reset();
        s.push_back(st(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            s.push_back(st(1, 2, 1, 0, 0, 6, 0, 0, 1, 0, 0, 1, 0, 1));
        end
        s.push_back(st(1, 2, 1, 0, 0, 6, 0, 0, 0, 0, 0, 1, 1, 0));
        s.push_back(st(1, 2, 1, 0, 0, 6, 0, 0, 0, 2, 0, 0, 0, 0));
        foreach (s[i]) begin
            @(negedge clk);
            apply(s[i]);
            e.tag = $sformatf("mem_wait[%0d]", i);
            e.v = exp_of(s[i]);
            sbq.push_back(e);
            #1;
            e = sbq.pop_front();
            n_cmp++;
            if (obs !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic test_flush_reset;
        step_t s[$];
        exp_t  e;
        do_reset();
        s.push_back(st(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(st(1, 4, 1, 0, 0, 8, 0, 1, 0, 0, 0, 0, 1, 0));
        s.push_back(st(1, 4, 1, 8, 1, 9, 0, 0, 0, 2, 0, 0, 0, 0));
        s.push_back(st(1, 9, 1, 4, 1, 4'hF, 0, 0, 1, 1, 3, 1, 0, 1));
        s.push_back(st(0, 9, 1, 4, 1, 4'hF, 0, 0, 1, 0, 0, 0, 0, 0));
        s.push_back(st(1, 9, 1, 4, 1, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (s[i]) begin
            @(negedge clk);
            apply(s[i]);
            e.tag = $sformatf("flush_reset[%0d]", i);
            e.v = exp_of(s[i]);
            sbq.push_back(e);
            #1;
            e = sbq.pop_front();
            n_cmp++;
            if (obs !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", e.tag, obs, e.v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ex_bypass();
        test_load_use();
        test_priority();
        test_mem_wait();
        test_flush_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
